// File: rtl/serial_comp2.sv
// Bit-serial two's-complement negator / pass-through, LSB first, with
// valid/ready handshakes on both sides and an overflow flag for the most-negative word.
module serial_comp2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    // Handshakes: a word transfers on a rising edge where valid and ready are both high;
    // out_valid and its data stay stable until that edge, and in_ready is high only in IDLE.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    count;
    logic             seen1;
    logic             mode;
    logic             ovf;
    logic             obit;

    // Copy bits up to and including the first 1, then invert the rest.
    always_comb begin
        obit = (mode && seen1) ? ~word[0] : word[0];
    end

    // Result bits enter at the top of the word as operand bits leave the bottom,
    // so after WIDTH shifts the register holds the complete result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            count     <= '0;
            seen1     <= 1'b0;
            mode      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word     <= in_data;
                        mode     <= in_mode;
                        ovf      <= in_mode && (in_data == MIN_NEG);
                        count    <= '0;
                        seen1    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    word  <= {obit, word[WIDTH-1:1]};
                    seen1 <= seen1 | word[0];
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        out_data  <= {obit, word[WIDTH-1:1]};
                        out_ovf   <= ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp2.sv
// Directed bench for serial_comp2: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
module tb_serial_comp2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv4, ir4, im4, ov4, or4, oo4, b4;
    logic [3:0] id4, od4;
    logic       iv8, ir8, im8, ov8, or8, oo8, b8;
    logic [7:0] id8, od8;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_comp2 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .in_mode(im4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_ovf(oo4), .busy(b4)
    );

    serial_comp2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_mode(im8), .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_ovf(oo8), .busy(b8)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        iv4 = 1'b1; id4 = 4'h3;  im4 = 1'b1; or4 = 1'b0;
        iv8 = 1'b1; id8 = 8'h01; im8 = 1'b1; or8 = 1'b0;
        step;
        step;
        checks++; if (ir4 !== 1'b1)  begin errors++; $display("FAIL reset4 in_ready got %b want 1", ir4); end
        checks++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL reset4 out_valid got %b want 0", ov4); end
        checks++; if (od4 !== 4'h0)  begin errors++; $display("FAIL reset4 out_data got %h want 0", od4); end
        checks++; if (oo4 !== 1'b0)  begin errors++; $display("FAIL reset4 out_ovf got %b want 0", oo4); end
        checks++; if (b4 !== 1'b0)   begin errors++; $display("FAIL reset4 busy got %b want 0", b4); end
        checks++; if (ir8 !== 1'b1)  begin errors++; $display("FAIL reset8 in_ready got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0)  begin errors++; $display("FAIL reset8 out_valid got %b want 0", ov8); end
        checks++; if (od8 !== 8'h00) begin errors++; $display("FAIL reset8 out_data got %h want 0", od8); end
        checks++; if (oo8 !== 1'b0)  begin errors++; $display("FAIL reset8 out_ovf got %b want 0", oo8); end
        checks++; if (b8 !== 1'b0)   begin errors++; $display("FAIL reset8 busy got %b want 0", b8); end
        iv4 = 1'b0; iv8 = 1'b0;
        rst_n = 1'b1;
        step;
        checks++; if (b4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL reset4_nocapture busy=%b in_ready=%b want 0/1", b4, ir4); end
        checks++; if (b8 !== 1'b0 || ir8 !== 1'b1) begin errors++; $display("FAIL reset8_nocapture busy=%b in_ready=%b want 0/1", b8, ir8); end
    endtask

    // One word through the 4-bit instance with out_ready held high.
    task automatic send4(input logic [3:0] d, input logic m, input logic [3:0] ed,
                         input logic eo, input string name);
        int n;
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", name, ir4); end
        iv4 = 1'b1; id4 = d; im4 = m; or4 = 1'b1;
        step;
        iv4 = 1'b0;
        n = 0;
        while (ov4 !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL %s latency got %0d want 4", name, n); end
        checks++; if (od4 !== ed) begin errors++; $display("FAIL %s data x=%h got %h want %h", name, d, od4, ed); end
        checks++; if (oo4 !== eo) begin errors++; $display("FAIL %s ovf x=%h got %b want %b", name, d, oo4, eo); end
        step;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL %s consume out_valid got %b want 0", name, ov4); end
    endtask

    task automatic send8(input logic [7:0] d, input logic [7:0] ed, input logic eo, input string name);
        int n;
        iv8 = 1'b1; id8 = d; im8 = 1'b1; or8 = 1'b1;
        step;
        iv8 = 1'b0;
        n = 0;
        while (ov8 !== 1'b1 && n < 30) begin
            step;
            n++;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL %s latency got %0d want 8", name, n); end
        checks++; if (od8 !== ed) begin errors++; $display("FAIL %s data got %h want %h", name, od8, ed); end
        checks++; if (oo8 !== eo) begin errors++; $display("FAIL %s ovf got %b want %b", name, oo8, eo); end
        step;
    endtask

    task automatic test_negate_all4;
        logic [3:0] x, e;
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            e = ~x + 4'd1;
            send4(x, 1'b1, e, (x == 4'b1000), "negate4");
        end
    endtask

    task automatic test_pass4;
        send4(4'b1010, 1'b0, 4'b1010, 1'b0, "pass4_1010");
        send4(4'b1000, 1'b0, 4'b1000, 1'b0, "pass4_1000");
    endtask

    task automatic test_backpressure;
        int n;
        iv4 = 1'b1; id4 = 4'b0011; im4 = 1'b1; or4 = 1'b0;
        step;
        iv4 = 1'b0;
        n = 0;
        while (ov4 !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp latency got %0d want 4", n); end
        for (int c = 0; c < 5; c++) begin
            iv4 = 1'b1;
            id4 = 4'($urandom_range(0, 15));
            im4 = 1'($urandom_range(0, 1));
            step;
            checks++; if (ov4 !== 1'b1)    begin errors++; $display("FAIL bp_hold out_valid cyc %0d got %b want 1", c, ov4); end
            checks++; if (od4 !== 4'b1101) begin errors++; $display("FAIL bp_hold out_data cyc %0d got %h want d", c, od4); end
            checks++; if (oo4 !== 1'b0)    begin errors++; $display("FAIL bp_hold out_ovf cyc %0d got %b want 0", c, oo4); end
            checks++; if (ir4 !== 1'b0)    begin errors++; $display("FAIL bp_hold in_ready cyc %0d got %b want 0", c, ir4); end
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        step;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL bp_release out_valid got %b want 0", ov4); end
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b want 1", ir4); end
        checks++; if (b4 !== 1'b0)  begin errors++; $display("FAIL bp_release busy got %b want 0", b4); end
    endtask

    task automatic test_reset_mid_shift;
        logic seen_valid;
        iv4 = 1'b1; id4 = 4'b0110; im4 = 1'b1; or4 = 1'b1;
        step;
        iv4 = 1'b0;
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        checks++; if (ir4 !== 1'b1 || b4 !== 1'b0 || ov4 !== 1'b0) begin
            errors++; $display("FAIL midreset state in_ready=%b busy=%b out_valid=%b want 1/0/0", ir4, b4, ov4);
        end
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step;
            if (ov4 === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL midreset aborted word out_valid got 1 want 0"); end
        send4(4'b0101, 1'b1, 4'b1011, 1'b0, "midreset_next");
    endtask

    task automatic test_width8;
        send8(8'h01, 8'hFF, 1'b0, "w8_01");
        send8(8'h80, 8'h80, 1'b1, "w8_80");
        send8(8'h7F, 8'h81, 1'b0, "w8_7f");
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [3];
        logic [7:0] e [3];
        logic       o [3];
        int         t [3];
        int         cyc, k;
        w = '{8'h01, 8'h7F, 8'h80};
        e = '{8'hFF, 8'h81, 8'h80};
        o = '{1'b0, 1'b0, 1'b1};
        t = '{0, 0, 0};
        iv8 = 1'b1; id8 = w[0]; im8 = 1'b1; or8 = 1'b1;
        cyc = 0;
        k = 0;
        while (k < 3 && cyc < 100) begin
            step;
            cyc++;
            if (ov8 === 1'b1) begin
                t[k] = cyc;
                checks++; if (od8 !== e[k] || oo8 !== o[k]) begin
                    errors++; $display("FAIL b2b word %0d got %h/%b want %h/%b", k, od8, oo8, e[k], o[k]);
                end
                k++;
                if (k < 3) id8 = w[k];
                else iv8 = 1'b0;
            end
        end
        iv8 = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b timeout words got %0d want 3", k); end
        checks++; if (t[1] - t[0] !== 10) begin errors++; $display("FAIL b2b spacing01 got %0d want 10", t[1] - t[0]); end
        checks++; if (t[2] - t[1] !== 10) begin errors++; $display("FAIL b2b spacing12 got %0d want 10", t[2] - t[1]); end
        step;
        step;
    endtask

    initial begin
        test_reset;
        test_negate_all4;
        test_pass4;
        test_backpressure;
        test_reset_mid_shift;
        test_width8;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
